alu_writeback: RTL and testbench



---
 rtl/rapids_pkg.sv | 33 +++
 rtl/rapids_fifo.sv | 59 +++++
 rtl/alu_writeback.sv | 106 ++++++++++
 tb/tb_alu_writeback.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rapids_pkg.sv
// Shared Rapids definitions: vec precision encoding, writeback entry layout,
// and the writeback beat state type.
package rapids_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;

  // Result precision encoding shared by the ALU and the writeback queue
  localparam logic [1:0] VEC_CHAR   = 2'd0;
  localparam logic [1:0] VEC_HALF   = 2'd1;
  localparam logic [1:0] VEC_FULL   = 2'd2;
  localparam logic [1:0] VEC_DOUBLE = 2'd3;

  // One queued ALU result pair
  typedef struct packed {
    logic [REG_AW-1:0] rd1;
    logic [REG_AW-1:0] rd2;
    logic [DATA_W-1:0] y1;
    logic [DATA_W-1:0] y2;
    logic              two;
  } wb_entry_t;

  typedef enum logic {
    BEAT_FIRST  = 1'b0,
    BEAT_SECOND = 1'b1
  } beat_t;

  // DOUBLE results and dual-result forms both need a second write beat
  function automatic logic needs_two(input logic [1:0] vec, input logic dual);
    return (vec == VEC_DOUBLE) || dual;
  endfunction

endpackage

// File: rtl/rapids_fifo.sv
// Circular buffer with occupancy count.
//   push/din   : write din at the tail (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   dout       : head entry, combinational from storage
//   full/empty : occupancy flags
//   count      : occupied entries, 0..DEPTH
module rapids_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// Result-writeback queue between the ALU and the register-file write port.
// Buffers result pairs and serializes each into one or two 32-bit writes.
//   in_valid/in_ready           : result-pair handshake (in_ready = !full)
//   in_vec, in_dual             : precision and dual-result flag
//   in_rd1/in_rd2, in_Y1/in_Y2  : destinations and data
//   wr_en/wr_ready              : register-file write handshake
//   wr_addr/wr_data             : write index/data (0 when idle)
//   count, busy                 : occupancy and non-empty flag
module alu_writeback
  import rapids_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_vec,
  input  logic                     in_dual,
  input  logic [AW-1:0]            in_rd1,
  input  logic [AW-1:0]            in_rd2,
  input  logic [31:0]              in_Y1,
  input  logic [31:0]              in_Y2,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [AW-1:0]            wr_addr,
  output logic [31:0]              wr_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  wb_entry_t   in_entry;
  wb_entry_t   head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  beat_t       beat;
  beat_t       beat_next;
  logic [AW-1:0] cur_addr;
  logic [31:0]   cur_data;
  logic          beat_done;

  assign in_ready = !full;
  assign busy     = !empty;
  assign push     = in_valid && !full;

  // Pack the offered result pair into a queue entry
  always_comb begin
    in_entry     = '0;
    in_entry.rd1 = REG_AW'(in_rd1);
    in_entry.rd2 = REG_AW'(in_rd2);
    in_entry.y1  = in_Y1;
    in_entry.y2  = in_Y2;
    in_entry.two = needs_two(in_vec, in_dual);
  end

  rapids_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Beat state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat <= BEAT_FIRST;
    else        beat <= beat_next;
  end

  // Beat sequencing and write decode; r0 beats complete without a write
  always_comb begin
    beat_next = beat;
    pop       = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    beat_done = 1'b0;
    cur_addr  = (beat == BEAT_FIRST) ? AW'(head.rd1) : AW'(head.rd2);
    cur_data  = (beat == BEAT_FIRST) ? head.y1 : head.y2;
    if (!empty) begin
      wr_addr   = cur_addr;
      wr_data   = cur_data;
      wr_en     = (cur_addr != '0);
      beat_done = (cur_addr == '0) || wr_ready;
      if (beat_done) begin
        if (beat == BEAT_FIRST && head.two) begin
          beat_next = BEAT_SECOND;
        end else begin
          beat_next = BEAT_FIRST;
          pop       = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: expected register writes are queued when
// a result is accepted and retired in order by a negedge monitor.
module tb_alu_writeback;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_vec;
  logic        in_dual;
  logic [4:0]  in_rd1;
  logic [4:0]  in_rd2;
  logic [31:0] in_y1;
  logic [31:0] in_y2;
  logic        wr_en;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  count;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_w;

  alu_writeback #(.DEPTH(DEPTH), .AW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .in_dual  (in_dual),
    .in_rd1   (in_rd1),
    .in_rd2   (in_rd2),
    .in_Y1    (in_y1),
    .in_Y2    (in_y2),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Retire expected writes as the register file accepts them
  always @(negedge clk) begin
    if (rst_n && wr_en && wr_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got write %0d=%h, required no write", wr_addr, wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          n_err++;
          $display("FAIL sb_order: got %0d=%h, required %0d=%h",
                   wr_addr, wr_data, exp_w[36:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one result for a cycle; on acceptance queue its expected writes
  task automatic offer(input logic [1:0] v, input logic d, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, output logic acc);
    cyc();
    in_valid = 1'b1;
    in_vec   = v;
    in_dual  = d;
    in_rd1   = r1;
    in_rd2   = r2;
    in_y1    = a;
    in_y2    = b;
    wr_ready = rdy;
    @(negedge clk);
    acc = in_ready;
    if (acc) begin
      if (r1 != 5'd0) exp_q.push_back({r1, a});
      if ((v == 2'd3 || d) && r2 != 5'd0) exp_q.push_back({r2, b});
    end
  endtask

  task automatic idle(input logic rdy);
    cyc();
    in_valid = 1'b0;
    wr_ready = rdy;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_vec = 2'd0; in_dual = 1'b0;
    in_rd1 = '0; in_rd2 = '0; in_y1 = '0; in_y2 = '0; wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (wr_en !== 1'b0)   begin n_err++; $display("FAIL rst_wr_en: got %b, required 0", wr_en); end
    n_vec++; if (wr_addr !== 5'd0) begin n_err++; $display("FAIL rst_wr_addr: got %0d, required 0", wr_addr); end
    n_vec++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL rst_wr_data: got %h, required 0", wr_data); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    n_vec++; if (count !== 3'd0)   begin n_err++; $display("FAIL rst_count: got %0d, required 0", count); end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_single_full();
    logic acc;
    offer(2'd2, 1'b0, 5'd3, 5'd9, 32'h12345678, 32'h99999999, 1'b1, acc);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b, required 1", acc); end
    idle(1'b1);
    n_vec++; if (wr_en !== 1'b1)  begin n_err++; $display("FAIL single_wr_en: got %b, required 1", wr_en); end
    n_vec++; if (wr_addr !== 5'd3) begin n_err++; $display("FAIL single_addr: got %0d, required 3", wr_addr); end
    n_vec++; if (wr_data !== 32'h12345678) begin n_err++; $display("FAIL single_data: got %h, required 12345678", wr_data); end
    idle(1'b1);
    n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL single_busy_drop: got %b, required 0", busy); end
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_en_drop: got %b, required 0", wr_en); end
  endtask

  task automatic test_double();
    logic acc;
    offer(2'd3, 1'b0, 5'd4, 5'd5, 32'hAAAA0000, 32'h0000BBBB, 1'b1, acc);
    idle(1'b1);
    n_vec++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd4, 32'hAAAA0000})
      begin n_err++; $display("FAIL double_beat1: got en=%b %0d=%h, required en=1 4=aaaa0000", wr_en, wr_addr, wr_data); end
    idle(1'b1);
    n_vec++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'h0000BBBB})
      begin n_err++; $display("FAIL double_beat2: got en=%b %0d=%h, required en=1 5=0000bbbb", wr_en, wr_addr, wr_data); end
    idle(1'b1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL double_done: got busy=%b, required 0", busy); end
  endtask

  task automatic test_stall();
    logic acc;
    int   acc_n = 0;
    int   guard = 0;
    for (int i = 0; i < 5; i++) begin
      offer(2'd2, 1'b0, 5'(10 + i), 5'd0, 32'hC0DE0000 + 32'(i), 32'd0, 1'b0, acc);
      if (acc) acc_n++;
    end
    n_vec++; if (acc_n != 4)       begin n_err++; $display("FAIL stall_accepted: got %0d, required 4", acc_n); end
    n_vec++; if (count !== 3'd4)   begin n_err++; $display("FAIL stall_count: got %0d, required 4", count); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
    offer(2'd2, 1'b0, 5'd14, 5'd0, 32'hC0DE0004, 32'd0, 1'b1, acc);
    n_vec++; if (acc !== 1'b0) begin n_err++; $display("FAIL stall_no_bypass: got %b, required 0", acc); end
    offer(2'd2, 1'b0, 5'd14, 5'd0, 32'hC0DE0004, 32'd0, 1'b1, acc);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL stall_fifth_accept: got %b, required 1", acc); end
    idle(1'b1);
    while (busy && guard < 20) begin
      idle(1'b1);
      guard++;
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall_drain: got busy=%b, required 0", busy); end
  endtask

  task automatic test_r0_skip();
    logic acc;
    offer(2'd0, 1'b1, 5'd0, 5'd7, 32'h00000011, 32'h00000022, 1'b1, acc);
    idle(1'b1);
    n_vec++; if ({busy, wr_en} !== 2'b10)
      begin n_err++; $display("FAIL r0_first: got busy=%b en=%b, required busy=1 en=0", busy, wr_en); end
    idle(1'b1);
    n_vec++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'h00000022})
      begin n_err++; $display("FAIL r0_second: got en=%b %0d=%h, required en=1 7=00000022", wr_en, wr_addr, wr_data); end
    idle(1'b1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL r0_done: got busy=%b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   acc_n = 0;
    int   guard = 0;
    // Random backpressure and random mix of precisions/destinations
    while (acc_n < 500 && guard < 5000) begin
      offer(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom, $urandom, 1'($urandom_range(0, 3) != 0), acc);
      if (acc) acc_n++;
      guard++;
    end
    // Fill the queue with the port stalled
    acc = 1'b1;
    guard = 0;
    while (acc && guard < 10) begin
      offer(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom, $urandom, 1'b0, acc);
      guard++;
    end
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL b2b_fill: got %0d, required 4", count); end
    // Continuous traffic against a full queue: occupancy must stay DEPTH-1..DEPTH
    acc_n = 0;
    guard = 0;
    while (acc_n < 500 && guard < 5000) begin
      offer(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom, $urandom, 1'b1, acc);
      if (acc) acc_n++;
      guard++;
      n_vec++;
      if (count < 3'd3 || count > 3'd4) begin
        n_err++; $display("FAIL b2b_occupancy: got %0d, required 3 or 4", count);
      end
    end
    n_vec++; if (acc_n != 500) begin n_err++; $display("FAIL b2b_progress: got %0d accepted, required 500", acc_n); end
    guard = 0;
    idle(1'b1);
    while (busy && guard < 50) begin
      idle(1'b1);
      guard++;
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic acc;
    offer(2'd3, 1'b0, 5'd4, 5'd5, 32'h11112222, 32'h33334444, 1'b1, acc);
    idle(1'b1);
    cyc();
    in_valid = 1'b0;
    wr_ready = 1'b0;
    @(negedge clk);
    n_vec++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'h33334444})
      begin n_err++; $display("FAIL mid_second_beat: got en=%b %0d=%h, required en=1 5=33334444", wr_en, wr_addr, wr_data); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_wr_en: got %b, required 0", wr_en); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d, required 0", count); end
    n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    offer(2'd2, 1'b0, 5'd6, 5'd5, 32'hCAFE0006, 32'hDEADBEEF, 1'b1, acc);
    idle(1'b1);
    n_vec++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd6, 32'hCAFE0006})
      begin n_err++; $display("FAIL mid_after: got en=%b %0d=%h, required en=1 6=cafe0006", wr_en, wr_addr, wr_data); end
    idle(1'b1);
    n_vec++; if ({busy, wr_en} !== 2'b00)
      begin n_err++; $display("FAIL mid_no_stale: got busy=%b en=%b, required 0 0", busy, wr_en); end
  endtask

  initial begin
    test_reset();
    test_single_full();
    test_double();
    test_stall();
    test_r0_skip();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending writes, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
